// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU core bus onto a synchronous single-port memory; optional ROM write guard via CPU_MEM_BRIDGE_ROM_PROTECT_EN.
// Latency: WAIT_STATES+3 cycles per access, request cycle included (IDLE -> ACCESS x (WAIT_STATES+1) -> DONE).
// Backpressure: cpu_enable stalls the core from request until DONE; cpu_enable is held low while rst is high.
module cpu_mem_bridge #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    WAIT_STATES = 1,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = 'hE000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rdwr,
    input  logic                  which_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic [DATA_WIDTH-1:0] cpu_data_in,
    output logic                  cpu_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    input  logic [DATA_WIDTH-1:0] mem_data_rd,
    output logic                  mem_re,
    output logic                  mem_we
`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
    ,
    output logic                  rom_wr_fault
`endif
);

    localparam logic       DIR_READ  = 1'b0;
    localparam logic       DIR_WRITE = 1'b1;
    localparam logic [3:0] WS_INIT   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       dir;
    logic       wr_blocked;
    logic       start;

    assign start = (state == IDLE) && req_rdwr;

`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
    // Evaluated on the latch edge, so it matches the address being captured.
    assign wr_blocked = (addr >= ROM_BASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_wr_fault <= 1'b0;
        end else if (start && (which_rdwr == DIR_WRITE) && wr_blocked) begin
            rom_wr_fault <= 1'b1;
        end
    end
`else
    logic unused_rom_base;
    assign wr_blocked      = 1'b0;
    assign unused_rom_base = ^ROM_BASE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            dir         <= DIR_READ;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data_wr <= '0;
            cpu_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_rdwr) begin
                        mem_addr    <= addr;
                        mem_data_wr <= cpu_data_out;
                        dir         <= which_rdwr;
                        mem_re      <= (which_rdwr == DIR_READ);
                        mem_we      <= (which_rdwr == DIR_WRITE) && !wr_blocked;
                        wait_cnt    <= WS_INIT;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Strobes are single-cycle: only the first ACCESS cycle sees them.
                    mem_re <= 1'b0;
                    mem_we <= 1'b0;
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (dir == DIR_READ) begin
                            cpu_data_in <= mem_data_rd;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Core advances once per access (edge ending DONE), or freely when idle with no request.
    assign cpu_enable = !rst && (((state == IDLE) && !req_rdwr) || (state == DONE));

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomised self-checking bench for cpu_mem_bridge against a transaction-level memory model.
module tb_cpu_mem_bridge;

    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_abs = 0;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    // Main DUT (WAIT_STATES=1)
    logic        req_rdwr, which_rdwr;
    logic [15:0] addr, mem_addr;
    logic [7:0]  cpu_data_out, cpu_data_in, mem_data_wr, mem_data_rd;
    logic        cpu_enable, mem_re, mem_we;

    // Wait-state variants share one request stream
    logic        req_x, which_x;
    logic [15:0] addr_x, mem_addr0, mem_addr3;
    logic [7:0]  wdat_x, rd_in0, rd_in3, cpu_in0, cpu_in3, mwd0, mwd3;
    logic        en0, en3, re0, re3, we0, we3;

`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
    logic rom_wr_fault, fault0, fault3;
`endif

    cpu_mem_bridge #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .req_rdwr(req_rdwr), .which_rdwr(which_rdwr), .addr(addr),
        .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in), .cpu_enable(cpu_enable),
        .mem_addr(mem_addr), .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
        .mem_re(mem_re), .mem_we(mem_we)
`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
        , .rom_wr_fault(rom_wr_fault)
`endif
    );

    cpu_mem_bridge #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .req_rdwr(req_x), .which_rdwr(which_x), .addr(addr_x),
        .cpu_data_out(wdat_x), .cpu_data_in(cpu_in0), .cpu_enable(en0),
        .mem_addr(mem_addr0), .mem_data_wr(mwd0), .mem_data_rd(rd_in0),
        .mem_re(re0), .mem_we(we0)
`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
        , .rom_wr_fault(fault0)
`endif
    );

    cpu_mem_bridge #(.WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .rst(rst), .req_rdwr(req_x), .which_rdwr(which_x), .addr(addr_x),
        .cpu_data_out(wdat_x), .cpu_data_in(cpu_in3), .cpu_enable(en3),
        .mem_addr(mem_addr3), .mem_data_wr(mwd3), .mem_data_rd(rd_in3),
        .mem_re(re3), .mem_we(we3)
`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
        , .rom_wr_fault(fault3)
`endif
    );

    // Memory: background pattern plus written bytes. Main and WS3 ports have one cycle of read latency.
    logic [7:0] mem [0:65535];
    bit         wv  [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h7C;
    endfunction

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        return wv[a] ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        if (mem_re) mem_data_rd <= mem_read(mem_addr);
        if (mem_we) begin
            mem[mem_addr] <= mem_data_wr;
            wv[mem_addr]  <= 1'b1;
        end
        if (re3) rd_in3 <= mem_read(mem_addr3);
    end
    assign rd_in0 = mem_read(mem_addr0);

    // Reference model: bytes the core has written, and the last value a read returned.
    logic [7:0] ref_mem [int];
    logic [7:0] exp_rd;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : pat(a);
    endfunction

    typedef struct {
        int          done_cyc;
        int          re_cnt;
        int          we_cnt;
        int          s_cyc;
        int          s_abs;
        int          en_hi;
        int          hold_err;
        logic [15:0] s_addr;
        logic [7:0]  s_wdat;
        logic [7:0]  rdat;
    } obs_t;

    // Drives one access and records what the bridge did, cycle by cycle (cycle 0 = request cycle).
    task automatic do_access(input logic dir, input logic [15:0] a, input logic [7:0] d,
                             input logic keep_req, output obs_t o);
        int          c;
        logic [15:0] a1;
        logic [7:0]  d1;
        o.done_cyc = -1; o.re_cnt = 0; o.we_cnt = 0; o.s_cyc = -1; o.s_abs = -1;
        o.en_hi = 0; o.hold_err = 0; o.s_addr = '0; o.s_wdat = '0; o.rdat = '0;
        a1 = '0; d1 = '0;
        @(negedge clk);
        req_rdwr = 1'b1; which_rdwr = dir; addr = a; cpu_data_out = d;
        #1;
        if (cpu_enable) o.en_hi++;
        c = 0;
        while (o.done_cyc < 0 && c < 30) begin
            @(negedge clk);
            c++;
            if (mem_re || mem_we) begin
                o.s_cyc = c; o.s_abs = cyc_abs; o.s_addr = mem_addr; o.s_wdat = mem_data_wr;
            end
            if (mem_re) o.re_cnt++;
            if (mem_we) o.we_cnt++;
            if (c == 1) begin
                a1 = mem_addr; d1 = mem_data_wr;
            end else if (mem_addr !== a1 || mem_data_wr !== d1) begin
                o.hold_err++;
            end
            if (cpu_enable) begin
                o.en_hi++; o.done_cyc = c; o.rdat = cpu_data_in;
                req_rdwr = keep_req;
            end else begin
                // Everything but the latch edge must be ignored.
                req_rdwr = 1'($urandom); which_rdwr = 1'($urandom);
                addr = 16'($urandom); cpu_data_out = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_rdwr = 1'b0; which_rdwr = 1'b0; addr = '0; cpu_data_out = '0;
        req_x = 1'b0; which_x = 1'b0; addr_x = '0; wdat_x = '0;
        exp_rd = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", cpu_enable); end
        checks++; if ({mem_re, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b exp 00", {mem_re, mem_we}); end
        checks++; if ({mem_addr, mem_data_wr, cpu_data_in} !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h exp 0", {mem_addr, mem_data_wr, cpu_data_in}); end
        rst = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL idle_en: got %b exp 1", cpu_enable); end
        // Reset in the middle of a read
        @(negedge clk);
        req_rdwr = 1'b1; which_rdwr = 1'b0; addr = 16'h2222;
        @(negedge clk);
        checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL midrst_re_before: got %b exp 1", mem_re); end
        rst = 1'b1; req_rdwr = 1'b0;
        #1;
        checks++; if ({cpu_enable, mem_re, mem_addr} !== 18'h0) begin errors++; $display("FAIL midrst_async: got %h exp 0", {cpu_enable, mem_re, mem_addr}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL midrst_release_en: got %b exp 1", cpu_enable); end
        repeat (3) begin
            @(negedge clk);
            checks++; if ({mem_re, mem_we, cpu_enable} !== 3'b001) begin errors++; $display("FAIL midrst_no_reissue: got %b exp 001", {mem_re, mem_we, cpu_enable}); end
        end
    endtask

    task automatic test_single_read();
        obs_t o;
        do_access(1'b0, 16'h1234, 8'h00, 1'b0, o);
        exp_rd = 8'h5A;
        checks++; if (o.done_cyc !== WS + 2) begin errors++; $display("FAIL rd_done_cycle: got %0d exp %0d", o.done_cyc, WS + 2); end
        checks++; if (o.re_cnt !== 1 || o.we_cnt !== 0 || o.s_cyc !== 1) begin errors++; $display("FAIL rd_strobe: got re=%0d we=%0d cyc=%0d exp 1 0 1", o.re_cnt, o.we_cnt, o.s_cyc); end
        checks++; if (o.s_addr !== 16'h1234) begin errors++; $display("FAIL rd_addr: got %h exp 1234", o.s_addr); end
        checks++; if (o.en_hi !== 1) begin errors++; $display("FAIL rd_enable_pulses: got %0d exp 1", o.en_hi); end
        checks++; if (o.rdat !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h exp 5a", o.rdat); end
    endtask

    task automatic test_single_write();
        obs_t o;
        do_access(1'b1, 16'h0040, 8'hC3, 1'b0, o);
        ref_mem[32'h40] = 8'hC3;
        checks++; if (o.we_cnt !== 1 || o.re_cnt !== 0 || o.s_cyc !== 1) begin errors++; $display("FAIL wr_strobe: got we=%0d re=%0d cyc=%0d exp 1 0 1", o.we_cnt, o.re_cnt, o.s_cyc); end
        checks++; if ({o.s_addr, o.s_wdat} !== {16'h0040, 8'hC3}) begin errors++; $display("FAIL wr_bus: got %h exp 0040c3", {o.s_addr, o.s_wdat}); end
        checks++; if (o.rdat !== exp_rd) begin errors++; $display("FAIL wr_keeps_rdata: got %h exp %h", o.rdat, exp_rd); end
        checks++; if (o.done_cyc !== WS + 2 || o.hold_err !== 0) begin errors++; $display("FAIL wr_timing: got done=%0d hold=%0d exp %0d 0", o.done_cyc, o.hold_err, WS + 2); end
        do_access(1'b0, 16'h0040, 8'h00, 1'b0, o);
        exp_rd = 8'hC3;
        checks++; if (o.rdat !== 8'hC3) begin errors++; $display("FAIL wr_readback: got %h exp c3", o.rdat); end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        do_access(1'b0, 16'h0001, 8'h00, 1'b1, o1);
        do_access(1'b1, 16'h0002, 8'h96, 1'b0, o2);
        ref_mem[32'h2] = 8'h96;
        exp_rd = pat(16'h0001);
        checks++; if (o2.s_abs - o1.s_abs !== WS + 3) begin errors++; $display("FAIL b2b_spacing: got %0d exp %0d", o2.s_abs - o1.s_abs, WS + 3); end
        checks++; if (o1.en_hi !== 1 || o2.en_hi !== 1) begin errors++; $display("FAIL b2b_enable: got %0d %0d exp 1 1", o1.en_hi, o2.en_hi); end
        checks++; if (o1.re_cnt !== 1 || o2.we_cnt !== 1 || o2.s_addr !== 16'h0002) begin errors++; $display("FAIL b2b_strobes: got re=%0d we=%0d a=%h exp 1 1 0002", o1.re_cnt, o2.we_cnt, o2.s_addr); end
        checks++; if (o1.rdat !== 8'h7D || o2.rdat !== 8'h7D) begin errors++; $display("FAIL b2b_rdata: got %h %h exp 7d 7d", o1.rdat, o2.rdat); end
    endtask

    task automatic test_wait_states();
        int         d0, d3;
        logic [7:0] v0, v3, ev;
        ev = pat(16'h3456);
        d0 = -1; d3 = -1; v0 = '0; v3 = '0;
        @(negedge clk);
        req_x = 1'b1; which_x = 1'b0; addr_x = 16'h3456; wdat_x = 8'h00;
        #1;
        if (en0) d0 = 0;
        if (en3) d3 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            req_x = 1'b0; addr_x = 16'($urandom);
            if (en0 && d0 < 0) begin d0 = c; v0 = cpu_in0; end
            if (en3 && d3 < 0) begin d3 = c; v3 = cpu_in3; end
        end
        checks++; if (d0 !== 2) begin errors++; $display("FAIL ws0_cycles: got %0d exp 2", d0); end
        checks++; if (d3 !== 5) begin errors++; $display("FAIL ws3_cycles: got %0d exp 5", d3); end
        checks++; if (v0 !== ev || v3 !== ev) begin errors++; $display("FAIL ws_rdata: got %h %h exp %h", v0, v3, ev); end
    endtask

`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
    task automatic test_rom_protect();
        obs_t o;
        checks++; if (rom_wr_fault !== 1'b0) begin errors++; $display("FAIL rom_fault_init: got %b exp 0", rom_wr_fault); end
        do_access(1'b1, 16'hE000, 8'hFF, 1'b0, o);
        checks++; if (o.we_cnt !== 0 || o.done_cyc !== WS + 2) begin errors++; $display("FAIL rom_blocked: got we=%0d done=%0d exp 0 %0d", o.we_cnt, o.done_cyc, WS + 2); end
        checks++; if (rom_wr_fault !== 1'b1) begin errors++; $display("FAIL rom_fault_set: got %b exp 1", rom_wr_fault); end
        do_access(1'b1, 16'hDFFF, 8'h11, 1'b0, o);
        ref_mem[32'hDFFF] = 8'h11;
        checks++; if (o.we_cnt !== 1 || o.s_addr !== 16'hDFFF) begin errors++; $display("FAIL rom_below_base: got we=%0d a=%h exp 1 dfff", o.we_cnt, o.s_addr); end
        checks++; if (rom_wr_fault !== 1'b1) begin errors++; $display("FAIL rom_fault_sticky: got %b exp 1", rom_wr_fault); end
    endtask
`endif

    task automatic test_random();
        obs_t        o;
        logic        dir, keep;
        logic [15:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 40; i++) begin
            dir  = 1'($urandom);
            a    = 16'h0100 + 16'($urandom_range(0, 15));
            d    = 8'($urandom);
            keep = (i < 39) ? 1'($urandom) : 1'b0;
            do_access(dir, a, d, keep, o);
            if (dir) ref_mem[int'(a)] = d;
            else     exp_rd = ref_read(a);
            checks++;
            if (o.done_cyc !== WS + 2 || o.en_hi !== 1 || o.hold_err !== 0 || o.s_cyc !== 1 ||
                o.re_cnt !== int'(!dir) || o.we_cnt !== int'(dir) || o.s_addr !== a ||
                (dir && o.s_wdat !== d) || o.rdat !== exp_rd) begin
                errors++;
                $display("FAIL rand_%0d: got dir=%b done=%0d en=%0d hold=%0d re=%0d we=%0d a=%h wd=%h rd=%h exp a=%h wd=%h rd=%h",
                         i, dir, o.done_cyc, o.en_hi, o.hold_err, o.re_cnt, o.we_cnt, o.s_addr, o.s_wdat, o.rdat, a, d, exp_rd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_wait_states();
`ifdef CPU_MEM_BRIDGE_ROM_PROTECT_EN
        test_rom_protect();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
